// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock.
// A single 4-bit adder is reused every cycle. The carry between nibbles is
// held in a register. Operands enter through a valid/ready handshake, and the
// result leaves through a second valid/ready handshake.

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic [CntW-1:0] r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [4:0]      w_nib_sum;
  logic [W-1:0]    w_sum_next;
  logic            w_last;

  // The single 4-bit adder stage: low nibbles of both operands plus the
  // carry from the previous nibble.
  assign w_nib_sum = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};

  // The final nibble is processed when the counter reaches NIBBLES-1.
  assign w_last = (r_cnt == CntW'(NIBBLES - 1));

  // The result register shifts right and takes the new nibble in at the top.
  // After NIBBLES shifts, nibble 0 has reached the bottom.
  always_comb begin
    w_sum_next            = r_sum >> 4;
    w_sum_next[W-1 -: 4]  = w_nib_sum[3:0];
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // in_ready is high only in this state, so in_valid alone
          // completes the handshake.
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StAdd;
          end
        end

        StAdd: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_sum   <= w_sum_next;
          r_carry <= w_nib_sum[4];
          r_cnt   <= r_cnt + CntW'(1);
          if (w_last) begin
            r_cout      <= w_nib_sum[4];
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end

        StDone: begin
          // sum and cout stay frozen until the consumer takes them. They
          // remain held after that, until the next operation starts shifting.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder.
// One instance uses NIBBLES=4 and a second instance uses NIBBLES=1.
// Every expected result comes from plain wide-integer addition.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  // NIBBLES=4 instance
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  // NIBBLES=1 instance
  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [3:0]  a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next rising edge and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until out_valid rises. Flag busy/in_ready misbehaviour on
  // the way.
  task automatic wait_valid(output int lat, output bit bad);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) bad = 1;
      step();
      lat++;
    end
  endtask

  // One complete operation on the 4-nibble instance.
  // hold: number of DONE cycles with out_ready low.
  // early: assert out_ready before out_valid.
  task automatic op4(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                     input int hold, input bit early, input string tag);
    logic [16:0] exp;
    int          lat;
    int          guard;
    bit          bad;
    exp   = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // The latched copies must be used from here on.
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    if (early) out_ready = 1'b1;
    wait_valid(lat, bad);
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_busy"}, {31'b0, bad}, 32'd0);
    check({tag, "_sum"}, {16'b0, sum}, {16'b0, exp[15:0]});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp[16]});
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;  // must be ignored while busy
        step();
        check({tag, "_hold_sum"}, {15'b0, cout, sum}, {15'b0, exp});
        check({tag, "_hold_ov"}, {30'b0, out_valid, in_ready}, 32'd2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    out_ready = 1'b0;
    check({tag, "_post"}, {29'b0, out_valid, in_ready, busy}, 32'd2);
    check({tag, "_kept"}, {15'b0, cout, sum}, {15'b0, exp});
  endtask

  // One complete operation on the 1-nibble instance.
  task automatic op1(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     input string tag);
    logic [4:0] exp;
    int         lat;
    exp = {1'b0, ta} + {1'b0, tb} + {4'b0, tc};
    a1 = ta; b1 = tb; cin1 = tc; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom);
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd1);
    check({tag, "_res"}, {27'b0, cout1, sum1}, {27'b0, exp});
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check({tag, "_post"}, {30'b0, out_valid1, in_ready1}, 32'd1);
  endtask

  initial begin
    int          lat;
    bit          bad;
    logic [15:0] ra, rb;
    logic        rc;

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    #12;
    check("rst_state", {28'b0, out_valid, in_ready, busy, cout}, 32'h4);
    check("rst_sum", {16'b0, sum}, 32'h0);
    check("rst1_state", {27'b0, out_valid1, in_ready1, busy1, cout1, 1'b0}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    op4(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ffff_p1");
    op4(16'h1234, 16'h4321, 1'b1, 0, 1'b0, "1234_4321");
    op4(16'h00FF, 16'h0001, 1'b0, 5, 1'b0, "backpressure");
    op4(16'h7777, 16'h8888, 1'b1, 0, 1'b1, "early_ready");

    // Reset during the second ADD cycle
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sum", {15'b0, cout, sum}, 32'h0);
    check("midrst_ctl", {29'b0, out_valid, in_ready, busy}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    op4(16'h0002, 16'h0003, 1'b0, 0, 1'b0, "after_rst");

    // Back-to-back with in_valid held high
    step();
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h8000; b = 16'h8000;
    wait_valid(lat, bad);
    check("b2b1_lat", lat, 32'd4);
    check("b2b1_busy", {31'b0, bad}, 32'd0);
    check("b2b1_res", {15'b0, cout, sum}, 32'h0_0002);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_idle", {30'b0, in_ready, busy}, 32'h2);
    step();
    in_valid = 1'b0;
    check("b2b2_acc", {30'b0, in_ready, busy}, 32'h1);
    wait_valid(lat, bad);
    check("b2b2_lat", lat, 32'd4);
    check("b2b2_res", {15'b0, cout, sum}, 32'h1_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Single-nibble instance
    op1(4'hF, 4'hA, 1'b0, "n1_fa");
    for (int i = 0; i < 8; i++) op1(4'($urandom), 4'($urandom), 1'($urandom), "n1_rnd");

    // Randomized operations on the 4-nibble instance
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;  // exercise a full carry chain
      op4(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit in case a handshake never completes.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential multi-word adder that adds two operands of 4*NIBBLES bits using a single 4-bit ripple-carry add per clock. The carry is registered between nibbles. It sits directly around the 4-bit adder stage. Upstream, it splits wide operands into nibbles and feeds them to the 4-bit stage. Downstream, it collects the nibble sums and final carry into a wide result. Both the input and output sides use valid/ready handshakes.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set a/b/cin is valid
in_ready  output  1  block can accept an operand set
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in into nibble 0
out_valid  output  1  sum/cout hold a valid result
out_ready  input  1  consumer accepts the result
sum  output  W  registered result a+b+cin, modulo 2^W
cout  output  1  carry out of the top nibble
busy  output  1  high in ADD or DONE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values:
  - State = IDLE; in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0.
  - Internal operand shift registers, carry register and nibble counter = 0.
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready at a rising edge: load a and b into shift registers, carry<=cin, cnt<=0, go to ADD.
    - in_valid without the handshake has no effect.
  - ADD: each cycle
    - compute {c,s} = a_sh[3:0] + b_sh[3:0] + carry (5-bit result);
    - shift a_sh and b_sh right by 4;
    - shift the result register right by 4 with s inserted at bits [W-1:W-4];
    - carry<=c; cnt<=cnt+1.
    - When cnt==NIBBLES-1, go to DONE on that edge and latch cout<=c. After NIBBLES shifts, the result register is sum.
    - in_ready=0.
  - DONE:
    - out_valid=1; sum/cout are stable.
    - On out_ready at a rising edge: out_valid<=0, go to IDLE.
    - in_ready=0, so no overlap of accept and deliver.
- Latency and throughput:
  - Operand accepted at edge k; out_valid rises after edge k+NIBBLES.
  - Minimum initiation interval is NIBBLES+2 cycles (accept, NIBBLES adds, output handshake edge returns to IDLE).
- sum only changes during ADD (as a shift register), and only while out_valid=0. After the output handshake, sum/cout keep the last result until the next operation starts shifting.
- Counter width is max(1, clog2(NIBBLES)).
- NIBBLES=1: a single ADD cycle, then DONE.
- Arithmetic is pure unsigned modulo 2^W; cout is the true carry out of bit W-1. No overflow flag.
- Boundary conditions:
  - out_ready high before out_valid: ignored; no state change.
  - in_valid held high while busy: ignored. It is accepted only in IDLE, so never earlier than the cycle after the output handshake.
  - Operands a/b/cin may change freely after acceptance; the block uses only its latched copies.
  - Reset mid-ADD or mid-DONE: the operation is abandoned. All outputs return to their reset values, and no partial result is ever presented.
- No X propagation: every register has a defined reset value and a next-state value in every state.

Test Plan:
- NIBBLES=4: a=16'hFFFF, b=16'h0001, cin=0 -> out_valid 4 cycles after accept; sum=16'h0000, cout=1.
- NIBBLES=4: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; busy high from accept until the output handshake.
- Backpressure: finish a 16'h00FF+16'h0001 op (sum=16'h0100), then hold out_ready=0 for 5 cycles -> out_valid stays 1, sum/cout stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- Reset mid-op: accept a=16'hABCD, b=16'h1111, then drive rst_n=0 during the 2nd ADD cycle between clock edges -> sum=0, cout=0, out_valid=0, in_ready=1 immediately. After release, 16'h0002+16'h0003 -> sum=16'h0005.
- NIBBLES=1: a=4'hF, b=4'hA, cin=0 -> latency 1 cycle, sum=4'h9, cout=1.
- Back-to-back: in_valid held high with op1 (16'h0001+16'h0001) then op2 (16'h8000+16'h8000) -> op2 accepted only in the IDLE cycle after op1's output handshake. Results: 16'h0002/cout=0, then 16'h0000/cout=1.
